// File: rtl/median_line_buffer.sv
// -----------------------------------------------------------------------------
// median_line_buffer
// Raster-to-column converter for the 11x11 median window. Pixels arrive one
// per cycle in raster order; the last 10 image rows live in circular line RAMs.
// Every accepted pixel (or flush step) yields one 11-tall column one cycle
// later. After the last image row, 5 padded rows are flushed so bottom-edge
// pixels still reach the window centre.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   sof_i          start of frame, qualified by din_valid_i on pixel (0,0)
//   din_valid_i    input pixel valid
//   din_i          input pixel (DW bits), raster order
//   din_ready_o    block accepts din_i this cycle
//   pixel0_o..10   column output, pixel0 = row y-10 (oldest), pixel10 = row y
//   clken_o        column valid strobe for the window shift register
//   out_row_o      row index of pixel10 (window centre row = out_row_o - 5)
//   out_col_o      column index of the emitted column
//   frame_done_o   one-cycle pulse together with the final flush column
// -----------------------------------------------------------------------------
module median_line_buffer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW = 9,
  parameter logic [DW-1:0] PAD_VAL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         sof_i,
  input  logic                         din_valid_i,
  input  logic [DW-1:0]                din_i,
  output logic                         din_ready_o,
  output logic [DW-1:0]                pixel0_o,
  output logic [DW-1:0]                pixel1_o,
  output logic [DW-1:0]                pixel2_o,
  output logic [DW-1:0]                pixel3_o,
  output logic [DW-1:0]                pixel4_o,
  output logic [DW-1:0]                pixel5_o,
  output logic [DW-1:0]                pixel6_o,
  output logic [DW-1:0]                pixel7_o,
  output logic [DW-1:0]                pixel8_o,
  output logic [DW-1:0]                pixel9_o,
  output logic [DW-1:0]                pixel10_o,
  output logic                         clken_o,
  output logic [$clog2(IMG_H+5)-1:0]   out_row_o,
  output logic [$clog2(IMG_W)-1:0]     out_col_o,
  output logic                         frame_done_o
);

  localparam int RW = $clog2(IMG_H + 5);
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_IMG_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FLUSH_LAST = RW'(IMG_H + 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0] sel_q, sel_d;
  logic [3:0] fill_q, fill_d;
  logic ready_q, ready_d;

  logic restartHit;
  logic stepEn;
  logic lastFlush;
  logic [CW-1:0] colEff;
  logic [RW-1:0] rowEff;
  logic [3:0] selEff;
  logic [3:0] fillEff;
  logic [DW-1:0] writeData;

  logic [DW-1:0] line_ram_q [10][IMG_W];
  logic [DW-1:0] pix_q [11];
  logic clken_q;
  logic frame_done_q;
  logic [RW-1:0] out_row_q;
  logic [CW-1:0] out_col_q;

  // Maps window slot k onto the physical line RAM: slot 0 is the RAM about to
  // be overwritten, i.e. the oldest stored row.
  function automatic logic [3:0] rot_idx(input logic [3:0] sel, input logic [3:0] k);
    logic [4:0] s;
    s = {1'b0, sel} + {1'b0, k};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end
    return s[3:0];
  endfunction

  // Next-state logic. A sof with valid restarts the frame in the same cycle, so
  // the counters seen by this step are forced to zero ("Eff" values) before
  // they are advanced. din_ready is registered so it reads 0 for the first
  // cycle after reset and during the whole flush.
  always_comb begin
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    sel_d = sel_q;
    fill_d = fill_q;

    restartHit = din_valid_i & sof_i & ready_q;
    stepEn = restartHit | ((state_q == ST_ACTIVE) & din_valid_i & ready_q) |
             (state_q == ST_FLUSH);
    lastFlush = (state_q == ST_FLUSH) && (row_q == ROW_FLUSH_LAST) && (col_q == COL_LAST);

    colEff = restartHit ? '0 : col_q;
    rowEff = restartHit ? '0 : row_q;
    selEff = restartHit ? '0 : sel_q;
    fillEff = restartHit ? '0 : fill_q;
    writeData = (state_q == ST_FLUSH) ? PAD_VAL : din_i;

    if (stepEn) begin
      if (colEff == COL_LAST) begin
        col_d = '0;
        row_d = rowEff + RW'(1);
        sel_d = (selEff == 4'd9) ? 4'd0 : selEff + 4'd1;
        fill_d = (fillEff == 4'd10) ? 4'd10 : fillEff + 4'd1;
      end else begin
        col_d = colEff + CW'(1);
        row_d = rowEff;
        sel_d = selEff;
        fill_d = fillEff;
      end

      if (restartHit) begin
        state_d = ST_ACTIVE;
      end
      if ((state_q != ST_FLUSH) && (colEff == COL_LAST) && (rowEff == ROW_IMG_LAST)) begin
        state_d = ST_FLUSH;
      end
      if (lastFlush) begin
        state_d = ST_IDLE;
        col_d = '0;
        row_d = '0;
        sel_d = '0;
        fill_d = '0;
      end
    end

    ready_d = (state_d != ST_FLUSH);
  end

  // State and position counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      row_q <= '0;
      sel_q <= '0;
      fill_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      sel_q <= sel_d;
      fill_q <= fill_d;
      ready_q <= ready_d;
    end
  end

  // Column output register. Slots k < 10-fill hold rows above the image top
  // and are forced to the pad value so stale RAM data never leaks into a
  // new frame. Outputs hold their values on cycles without a step.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 11; k++) begin
        pix_q[k] <= PAD_VAL;
      end
      clken_q <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      clken_q <= stepEn;
      frame_done_q <= stepEn & lastFlush;
      if (stepEn) begin
        for (int k = 0; k < 10; k++) begin
          if ((5'(k) + {1'b0, fillEff}) < 5'd10) begin
            pix_q[k] <= PAD_VAL;
          end else begin
            pix_q[k] <= line_ram_q[rot_idx(selEff, 4'(k))][colEff];
          end
        end
        pix_q[10] <= writeData;
        out_row_q <= rowEff;
        out_col_q <= colEff;
      end
    end
  end

  // Line RAM write port. The read above uses the pre-write contents, giving
  // read-first behaviour on the slot being replaced.
  always_ff @(posedge clk_i) begin
    if (stepEn) begin
      line_ram_q[selEff][colEff] <= writeData;
    end
  end

  assign din_ready_o = ready_q;
  assign clken_o = clken_q;
  assign frame_done_o = frame_done_q;
  assign out_row_o = out_row_q;
  assign out_col_o = out_col_q;
  assign pixel0_o = pix_q[0];
  assign pixel1_o = pix_q[1];
  assign pixel2_o = pix_q[2];
  assign pixel3_o = pix_q[3];
  assign pixel4_o = pix_q[4];
  assign pixel5_o = pix_q[5];
  assign pixel6_o = pix_q[6];
  assign pixel7_o = pix_q[7];
  assign pixel8_o = pix_q[8];
  assign pixel9_o = pix_q[9];
  assign pixel10_o = pix_q[10];

endmodule
